// File: rtl/byte_to_word_rx.sv
// Byte-to-word packer for the phy receive path.
// Packs BYTES accepted bytes MSB-first and strobes each finished word.
module byte_to_word_rx #(
  parameter int BYTES = 4
) (
  input  logic                     clk_4f,
  input  logic                     reset_L,
  input  logic [7:0]               data_in,
  input  logic                     valid_in,
  input  logic                     active,
  output logic [8*BYTES-1:0]       data_out,
  output logic                     valid_out,
  output logic [$clog2(BYTES)-1:0] byte_idx,
  output logic                     err_partial,
  output logic [7:0]               word_cnt
);

  localparam int IW = $clog2(BYTES);
  localparam int DW = 8 * BYTES;

  typedef enum logic {
    WAIT_ACTIVE,
    COLLECT
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [DW-1:0]   sh_next;
  logic            last;

  assign sh_next = {sh_q[DW-9:0], data_in};
  assign last    = (idx_q == IW'(BYTES - 1));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    data_d  = data_q;
    idx_d   = idx_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_ACTIVE: begin
        idx_d = '0;
        if (active) begin
          state_d = COLLECT;
          if (valid_in) begin
            sh_d  = sh_next;
            idx_d = IW'(1);
          end
        end
      end
      COLLECT: begin
        if (!active) begin
          // link lost: drop whatever partial word was in flight
          state_d = WAIT_ACTIVE;
          sh_d    = '0;
          idx_d   = '0;
          err_d   = (idx_q != '0);
        end else if (valid_in) begin
          sh_d = sh_next;
          if (last) begin
            idx_d  = '0;
            data_d = sh_next;
            vld_d  = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = WAIT_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= WAIT_ACTIVE;
      sh_q    <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = vld_q;
  assign byte_idx    = idx_q;
  assign err_partial = err_q;
  assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_byte_to_word_rx.sv
// Directed bench for byte_to_word_rx (BYTES=4).
// Steps drive one byte per clock and check outputs just after the edge.
`timescale 1ns/1ps
module tb_byte_to_word_rx;

  logic        clk_4f;
  logic        reset_L;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        active;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  byte_idx;
  logic        err_partial;
  logic [7:0]  word_cnt;

  int checks;
  int failures;
  int pulses;
  logic [31:0] exp_word;

  byte_to_word_rx #(.BYTES(4)) dut (
    .clk_4f      (clk_4f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .active      (active),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_idx    (byte_idx),
    .err_partial (err_partial),
    .word_cnt    (word_cnt)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic a);
    data_in  = d;
    valid_in = v;
    active   = a;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, data_out, 32'h0);
    chk({tag, "_vld"}, {31'b0, valid_out}, 32'h0);
    chk({tag, "_idx"}, {30'b0, byte_idx}, 32'h0);
    chk({tag, "_err"}, {31'b0, err_partial}, 32'h0);
    chk({tag, "_cnt"}, {24'b0, word_cnt}, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    active   = 1'b0;
    reset_L  = 1'b1;
    #1 reset_L = 1'b0;
    #1;
    chk_all_zero("rst_async");
    repeat (2) @(posedge clk_4f);
    #1 reset_L = 1'b1;
    chk_all_zero("rst_held");

    // 1: plain word
    step(8'hDD, 1'b1, 1'b1);
    chk("t1_idx1", {30'b0, byte_idx}, 32'd1);
    step(8'h45, 1'b1, 1'b1);
    chk("t1_idx2", {30'b0, byte_idx}, 32'd2);
    step(8'hAA, 1'b1, 1'b1);
    chk("t1_idx3", {30'b0, byte_idx}, 32'd3);
    chk("t1_novld", {31'b0, valid_out}, 32'd0);
    step(8'h13, 1'b1, 1'b1);
    chk("t1_vld", {31'b0, valid_out}, 32'd1);
    chk("t1_data", data_out, 32'hDD45AA13);
    chk("t1_cnt", {24'b0, word_cnt}, 32'd1);
    chk("t1_idx0", {30'b0, byte_idx}, 32'd0);
    step(8'h00, 1'b0, 1'b1);
    chk("t1_pulse1", {31'b0, valid_out}, 32'd0);
    chk("t1_hold", data_out, 32'hDD45AA13);

    // 2: idles in the middle of a word
    step(8'hDD, 1'b1, 1'b1);
    step(8'h45, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'hBC, 1'b0, 1'b1);
      chk("t2_idle_vld", {31'b0, valid_out}, 32'd0);
      chk("t2_idle_idx", {30'b0, byte_idx}, 32'd2);
    end
    step(8'hAA, 1'b1, 1'b1);
    chk("t2_novld", {31'b0, valid_out}, 32'd0);
    step(8'h13, 1'b1, 1'b1);
    chk("t2_vld", {31'b0, valid_out}, 32'd1);
    chk("t2_data", data_out, 32'hDD45AA13);
    chk("t2_cnt", {24'b0, word_cnt}, 32'd2);

    // 3: valid bytes while inactive are ignored
    step(8'hF2, 1'b1, 1'b0);
    chk("t3_idx_a", {30'b0, byte_idx}, 32'd0);
    chk("t3_err_a", {31'b0, err_partial}, 32'd0);
    chk("t3_vld_a", {31'b0, valid_out}, 32'd0);
    step(8'h15, 1'b1, 1'b0);
    chk("t3_idx_b", {30'b0, byte_idx}, 32'd0);
    chk("t3_vld_b", {31'b0, valid_out}, 32'd0);
    chk("t3_cnt", {24'b0, word_cnt}, 32'd2);

    // 4: active drop with a partial word
    step(8'hDD, 1'b1, 1'b1);
    chk("t4_idx1", {30'b0, byte_idx}, 32'd1);
    step(8'h45, 1'b1, 1'b1);
    step(8'hAA, 1'b1, 1'b1);
    chk("t4_idx3", {30'b0, byte_idx}, 32'd3);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_err", {31'b0, err_partial}, 32'd1);
    chk("t4_idx0", {30'b0, byte_idx}, 32'd0);
    chk("t4_data", data_out, 32'hDD45AA13);
    chk("t4_vld", {31'b0, valid_out}, 32'd0);
    step(8'h00, 1'b0, 1'b0);
    chk("t4_err_pulse", {31'b0, err_partial}, 32'd0);
    chk("t4_cnt", {24'b0, word_cnt}, 32'd2);

    // 5: back-to-back bytes, then count wrap
    for (int i = 1; i <= 8; i++) begin
      step(8'(i), 1'b1, 1'b1);
      if (i == 4) begin
        chk("t5_w0_vld", {31'b0, valid_out}, 32'd1);
        chk("t5_w0_data", data_out, 32'h01020304);
        chk("t5_w0_cnt", {24'b0, word_cnt}, 32'd3);
      end else if (i == 8) begin
        chk("t5_w1_vld", {31'b0, valid_out}, 32'd1);
        chk("t5_w1_data", data_out, 32'h05060708);
        chk("t5_w1_cnt", {24'b0, word_cnt}, 32'd4);
      end else begin
        chk("t5_gap_vld", {31'b0, valid_out}, 32'd0);
      end
    end
    pulses   = 0;
    exp_word = 32'h0;
    for (int w = 0; w < 252; w++) begin
      exp_word = {8'(w), ~8'(w), 8'h5A, 8'(w + 3)};
      step(exp_word[31:24], 1'b1, 1'b1);
      if (valid_out) pulses++;
      step(exp_word[23:16], 1'b1, 1'b1);
      if (valid_out) pulses++;
      step(exp_word[15:8], 1'b1, 1'b1);
      if (valid_out) pulses++;
      step(exp_word[7:0], 1'b1, 1'b1);
      if (valid_out) pulses++;
    end
    chk("t5_pulses", pulses, 32'd252);
    chk("t5_last", data_out, exp_word);
    chk("t5_wrap", {24'b0, word_cnt}, 32'd0);

    // 6: asynchronous reset mid-word
    step(8'hAA, 1'b1, 1'b1);
    step(8'hBB, 1'b1, 1'b1);
    chk("t6_idx2", {30'b0, byte_idx}, 32'd2);
    #2 reset_L = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    #1 reset_L = 1'b1;
    step(8'h11, 1'b1, 1'b1);
    chk("t6_err", {31'b0, err_partial}, 32'd0);
    chk("t6_idx1", {30'b0, byte_idx}, 32'd1);
    step(8'h22, 1'b1, 1'b1);
    step(8'h33, 1'b1, 1'b1);
    step(8'h44, 1'b1, 1'b1);
    chk("t6_vld", {31'b0, valid_out}, 32'd1);
    chk("t6_data", data_out, 32'h11223344);
    chk("t6_cnt", {24'b0, word_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
